// File: rtl/chirp_gen_responder_if.sv
// Chirp handshake and phase-increment bundle between the pulse controller / DAC path
// (master) and the chirp responder (slave).
interface chirp_gen_responder_if #(
    parameter int PHASE_W = 32
);
    logic               dac_ready;
    logic [127:0]       chirp_parameters_in;
    logic               chirp_init;
    logic               chirp_enable;
    logic               chirp_ready;
    logic               chirp_active;
    logic               chirp_done;
    logic               chirp_aborted;
    logic [PHASE_W-1:0] dds_phase_inc;
    logic               dds_phase_valid;
    logic [31:0]        chirp_sample_index;
    logic [31:0]        chirp_count_total;

    modport master (
        output dac_ready, chirp_parameters_in, chirp_init, chirp_enable,
        input  chirp_ready, chirp_active, chirp_done, chirp_aborted,
        input  dds_phase_inc, dds_phase_valid, chirp_sample_index, chirp_count_total
    );

    modport slave (
        input  dac_ready, chirp_parameters_in, chirp_init, chirp_enable,
        output chirp_ready, chirp_active, chirp_done, chirp_aborted,
        output dds_phase_inc, dds_phase_valid, chirp_sample_index, chirp_count_total
    );
endinterface

// File: rtl/chirp_gen_responder.sv
// Chirp responder: answers init/enable and emits a linear-FM phase-increment stream.
// Define CHIRP_SYMMETRIC_EN for a triangular (up then down) chirp.
module chirp_gen_responder #(
    parameter int PHASE_W        = 32,
    parameter int HOLDOFF_CYCLES = 4
) (
    input  logic                  clk_fmc150,
    input  logic                  resetn_fmc150,
    chirp_gen_responder_if.slave  bus
);
    localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READY,
        S_RUN,
        S_DONE,
        S_HOLDOFF
    } state_t;

    state_t             state_q, state_d;
    logic [HW-1:0]      hold_cnt_q, hold_cnt_d;
    logic [PHASE_W-1:0] coef_q, coef_d;
    logic [31:0]        max_q, max_d;
    logic [PHASE_W-1:0] acc_q, acc_d;
    logic [31:0]        k_q, k_d;
    logic [31:0]        count_q, count_d;
    logic               chirp_ready_q, chirp_ready_d;
    logic               chirp_active_q, chirp_active_d;
    logic               chirp_done_q, chirp_done_d;
    logic               chirp_aborted_q, chirp_aborted_d;
    logic [PHASE_W-1:0] phase_out_q, phase_out_d;
`ifdef CHIRP_SYMMETRIC_EN
    logic               down_q, down_d;
    logic [31:0]        dcnt_q, dcnt_d;
`endif
    logic               rst_sync_q;
    logic               abort_req;
    logic               unused_params;

    assign unused_params = ^bus.chirp_parameters_in[127:96];
    assign abort_req     = !bus.chirp_enable || !bus.dac_ready;

    // Reset asserts asynchronously, releases one clock after resetn rises.
    always_ff @(posedge clk_fmc150 or negedge resetn_fmc150) begin
        if (!resetn_fmc150) rst_sync_q <= 1'b0;
        else                rst_sync_q <= 1'b1;
    end

    always_comb begin
        state_d         = state_q;
        hold_cnt_d      = hold_cnt_q;
        coef_d          = coef_q;
        max_d           = max_q;
        acc_d           = acc_q;
        k_d             = k_q;
        count_d         = count_q;
        chirp_aborted_d = 1'b0;
`ifdef CHIRP_SYMMETRIC_EN
        down_d          = down_q;
        dcnt_d          = dcnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.dac_ready) state_d = S_READY;
            end
            S_READY: begin
                if (!bus.dac_ready) begin
                    state_d = S_IDLE;
                end else if (bus.chirp_init && bus.chirp_enable) begin
                    acc_d   = PHASE_W'(bus.chirp_parameters_in[95:64]);
                    coef_d  = PHASE_W'(bus.chirp_parameters_in[63:32]);
                    max_d   = bus.chirp_parameters_in[31:0];
                    k_d     = 32'd0;
                    state_d = S_RUN;
`ifdef CHIRP_SYMMETRIC_EN
                    down_d  = 1'b0;
                    dcnt_d  = 32'd0;
`endif
                end
            end
            S_RUN: begin
                // Abort takes priority over completion on the same edge.
                if (abort_req) begin
                    state_d         = S_HOLDOFF;
                    hold_cnt_d      = '0;
                    chirp_aborted_d = 1'b1;
`ifdef CHIRP_SYMMETRIC_EN
                end else if (down_q) begin
                    if (dcnt_q == max_q) begin
                        state_d = S_DONE;
                        count_d = count_q + 32'd1;
                    end else begin
                        acc_d  = acc_q - coef_q;
                        k_d    = k_q + 32'd1;
                        dcnt_d = dcnt_q + 32'd1;
                    end
                end else if (k_q == max_q) begin
                    if (max_q == 32'd0) begin
                        state_d = S_DONE;
                        count_d = count_q + 32'd1;
                    end else begin
                        down_d = 1'b1;
                        acc_d  = acc_q - coef_q;
                        k_d    = k_q + 32'd1;
                        dcnt_d = 32'd1;
                    end
`else
                end else if (k_q == max_q) begin
                    state_d = S_DONE;
                    count_d = count_q + 32'd1;
`endif
                end else begin
                    acc_d = acc_q + coef_q;
                    k_d   = k_q + 32'd1;
                end
            end
            S_DONE: begin
                state_d    = S_HOLDOFF;
                hold_cnt_d = '0;
            end
            S_HOLDOFF: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = bus.dac_ready ? S_READY : S_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they land registered with it.
        chirp_ready_d  = (state_d == S_READY);
        chirp_active_d = (state_d == S_RUN);
        chirp_done_d   = (state_d == S_DONE);
        phase_out_d    = chirp_active_d ? acc_d : '0;
    end

    always_ff @(posedge clk_fmc150 or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q         <= S_IDLE;
            hold_cnt_q      <= '0;
            coef_q          <= '0;
            max_q           <= '0;
            acc_q           <= '0;
            k_q             <= '0;
            count_q         <= '0;
            chirp_ready_q   <= 1'b0;
            chirp_active_q  <= 1'b0;
            chirp_done_q    <= 1'b0;
            chirp_aborted_q <= 1'b0;
            phase_out_q     <= '0;
`ifdef CHIRP_SYMMETRIC_EN
            down_q          <= 1'b0;
            dcnt_q          <= '0;
`endif
        end else begin
            state_q         <= state_d;
            hold_cnt_q      <= hold_cnt_d;
            coef_q          <= coef_d;
            max_q           <= max_d;
            acc_q           <= acc_d;
            k_q             <= k_d;
            count_q         <= count_d;
            chirp_ready_q   <= chirp_ready_d;
            chirp_active_q  <= chirp_active_d;
            chirp_done_q    <= chirp_done_d;
            chirp_aborted_q <= chirp_aborted_d;
            phase_out_q     <= phase_out_d;
`ifdef CHIRP_SYMMETRIC_EN
            down_q          <= down_d;
            dcnt_q          <= dcnt_d;
`endif
        end
    end

    assign bus.chirp_ready        = chirp_ready_q;
    assign bus.chirp_active       = chirp_active_q;
    assign bus.chirp_done         = chirp_done_q;
    assign bus.chirp_aborted      = chirp_aborted_q;
    assign bus.dds_phase_inc      = phase_out_q;
    assign bus.dds_phase_valid    = chirp_active_q;
    assign bus.chirp_sample_index = k_q;
    assign bus.chirp_count_total  = count_q;
endmodule
